// File: rtl/tob_tracker_if.sv
// rtl/tob_tracker_if.sv - tick stream and best-of-book bundle for tob_tracker
//
// Groups the tick stream from itch_decoder with the top-of-book and status
// outputs of tob_tracker.
//   master : tick source (drives tick_*, observes results)
//   slave  : tob_tracker (consumes tick_*, drives results)
interface tob_tracker_if;
  logic        tick_valid;
  logic        tick_type;
  logic [63:0] tick_oid;
  logic        tick_side;
  logic [31:0] tick_qty;
  logic [31:0] tick_price;

  logic        bbo_valid;
  logic        bid_present;
  logic        ask_present;
  logic [31:0] bid_price;
  logic [31:0] bid_qty;
  logic [31:0] ask_price;
  logic [31:0] ask_qty;
  logic        busy;
  logic [15:0] ovf_count;
  logic [15:0] err_count;

  modport master (
    output tick_valid, tick_type, tick_oid, tick_side, tick_qty, tick_price,
    input  bbo_valid, bid_present, ask_present, bid_price, bid_qty,
           ask_price, ask_qty, busy, ovf_count, err_count
  );

  modport slave (
    input  tick_valid, tick_type, tick_oid, tick_side, tick_qty, tick_price,
    output bbo_valid, bid_present, ask_present, bid_price, bid_qty,
           ask_price, ask_qty, busy, ovf_count, err_count
  );
endinterface

// File: rtl/tob_tracker.sv
// rtl/tob_tracker.sv - order table with best bid/ask publication
//
// Consumes add/delete ticks, keeps an order table keyed by order ID, and
// after every successfully applied tick rescans the table one entry per cycle
// to publish best bid (max buy price) and best ask (min sell price).
// Ticks have no backpressure; a FIFO absorbs bursts and drops are counted.
//
// Parameters: DEPTH (order-table entries), FIFO_DEPTH (tick FIFO entries).
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   tob (slave)      : tick_* inputs; bbo_valid pulse, bid/ask present,
//                      price, qty; busy; ovf_count, err_count (saturating)
// Build option: TOB_QTY_AGG_EN - when defined, published qty is the
//   saturating sum over all live orders at the best price; otherwise it is
//   the qty of the lowest-index live order at the best price.
module tob_tracker #(
  parameter int DEPTH      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  tob_tracker_if.slave tob
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic        typ;
    logic [63:0] oid;
    logic        side;
    logic [31:0] qty;
    logic [31:0] price;
  } tick_t;

  typedef enum logic [1:0] {IDLE, APPLY, SCAN} state_t;

  state_t state;

  // ---------------------------------------------------------------- FIFO
  tick_t          fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  fifo_cnt;
  logic [15:0]    ovf_cnt;
  logic           pop, push, drop;
  tick_t          tick_in;

  assign tick_in = '{typ: tob.tick_type, oid: tob.tick_oid, side: tob.tick_side,
                     qty: tob.tick_qty, price: tob.tick_price};

  assign pop  = (state == IDLE) && (fifo_cnt != '0);
  // A full FIFO still accepts a tick when the head leaves on the same edge.
  assign push = tob.tick_valid && ((fifo_cnt < CW'(FIFO_DEPTH)) || pop);
  assign drop = tob.tick_valid && !push;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= tick_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      ovf_cnt  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (drop && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------- order table
  logic [DEPTH-1:0] tbl_valid;
  logic [DEPTH-1:0] tbl_side;
  logic [63:0]      tbl_oid   [DEPTH];
  logic [31:0]      tbl_price [DEPTH];
  logic [31:0]      tbl_qty   [DEPTH];

  tick_t            work;
  logic [IW-1:0]    scan_idx;

  // Scan accumulators
  logic             bid_found, ask_found;
  logic [31:0]      bid_px_acc, bid_qty_acc, ask_px_acc, ask_qty_acc;

  // Registered outputs
  logic             bbo_valid_r, bid_present_r, ask_present_r;
  logic [31:0]      bid_price_r, bid_qty_r, ask_price_r, ask_qty_r;
  logic [15:0]      err_cnt;

  // Parallel OID match and lowest-index free slot for the work tick
  logic             hit, free_found;
  logic [IW-1:0]    hit_idx, free_idx;

  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!hit && tbl_valid[i] && tbl_oid[i] == work.oid) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
      if (!free_found && !tbl_valid[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
  end

`ifdef TOB_QTY_AGG_EN
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction
`endif

  // Accumulator update for the entry under scan_idx. The final SCAN edge
  // publishes these next-values so the last entry is included.
  logic        nb_found, na_found;
  logic [31:0] nb_px, nb_qty, na_px, na_qty;

  always_comb begin
    nb_found = bid_found;
    nb_px    = bid_px_acc;
    nb_qty   = bid_qty_acc;
    na_found = ask_found;
    na_px    = ask_px_acc;
    na_qty   = ask_qty_acc;
    if (tbl_valid[scan_idx] && !tbl_side[scan_idx]) begin
      if (!bid_found || tbl_price[scan_idx] > bid_px_acc) begin
        nb_found = 1'b1;
        nb_px    = tbl_price[scan_idx];
        nb_qty   = tbl_qty[scan_idx];
      end
`ifdef TOB_QTY_AGG_EN
      else if (tbl_price[scan_idx] == bid_px_acc) begin
        nb_qty = sat_add(bid_qty_acc, tbl_qty[scan_idx]);
      end
`endif
    end
    if (tbl_valid[scan_idx] && tbl_side[scan_idx]) begin
      if (!ask_found || tbl_price[scan_idx] < ask_px_acc) begin
        na_found = 1'b1;
        na_px    = tbl_price[scan_idx];
        na_qty   = tbl_qty[scan_idx];
      end
`ifdef TOB_QTY_AGG_EN
      else if (tbl_price[scan_idx] == ask_px_acc) begin
        na_qty = sat_add(ask_qty_acc, tbl_qty[scan_idx]);
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      work          <= '0;
      scan_idx      <= '0;
      tbl_valid     <= '0;
      tbl_side      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tbl_oid[i]   <= '0;
        tbl_price[i] <= '0;
        tbl_qty[i]   <= '0;
      end
      bid_found     <= 1'b0;
      ask_found     <= 1'b0;
      bid_px_acc    <= '0;
      bid_qty_acc   <= '0;
      ask_px_acc    <= '0;
      ask_qty_acc   <= '0;
      bbo_valid_r   <= 1'b0;
      bid_present_r <= 1'b0;
      ask_present_r <= 1'b0;
      bid_price_r   <= '0;
      bid_qty_r     <= '0;
      ask_price_r   <= '0;
      ask_qty_r     <= '0;
      err_cnt       <= '0;
    end else begin
      bbo_valid_r <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            work  <= fifo_mem[rd_ptr];
            state <= APPLY;
          end
        end

        APPLY: begin
          scan_idx    <= '0;
          bid_found   <= 1'b0;
          ask_found   <= 1'b0;
          bid_px_acc  <= '0;
          bid_qty_acc <= '0;
          ask_px_acc  <= '0;
          ask_qty_acc <= '0;
          state       <= IDLE;
          if (!work.typ) begin
            if (hit) begin
              tbl_side[hit_idx]  <= work.side;
              tbl_price[hit_idx] <= work.price;
              tbl_qty[hit_idx]   <= work.qty;
              state              <= SCAN;
            end else if (free_found) begin
              tbl_valid[free_idx] <= 1'b1;
              tbl_oid[free_idx]   <= work.oid;
              tbl_side[free_idx]  <= work.side;
              tbl_price[free_idx] <= work.price;
              tbl_qty[free_idx]   <= work.qty;
              state               <= SCAN;
            end else if (err_cnt != 16'hFFFF) begin
              err_cnt <= err_cnt + 1'b1;
            end
          end else begin
            if (hit) begin
              tbl_valid[hit_idx] <= 1'b0;
              state              <= SCAN;
            end else if (err_cnt != 16'hFFFF) begin
              err_cnt <= err_cnt + 1'b1;
            end
          end
        end

        SCAN: begin
          bid_found   <= nb_found;
          bid_px_acc  <= nb_px;
          bid_qty_acc <= nb_qty;
          ask_found   <= na_found;
          ask_px_acc  <= na_px;
          ask_qty_acc <= na_qty;
          scan_idx    <= scan_idx + 1'b1;
          if (scan_idx == IW'(DEPTH - 1)) begin
            bbo_valid_r   <= 1'b1;
            bid_present_r <= nb_found;
            bid_price_r   <= nb_found ? nb_px  : 32'd0;
            bid_qty_r     <= nb_found ? nb_qty : 32'd0;
            ask_present_r <= na_found;
            ask_price_r   <= na_found ? na_px  : 32'd0;
            ask_qty_r     <= na_found ? na_qty : 32'd0;
            state         <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign tob.bbo_valid   = bbo_valid_r;
  assign tob.bid_present = bid_present_r;
  assign tob.ask_present = ask_present_r;
  assign tob.bid_price   = bid_price_r;
  assign tob.bid_qty     = bid_qty_r;
  assign tob.ask_price   = ask_price_r;
  assign tob.ask_qty     = ask_qty_r;
  assign tob.busy        = (state != IDLE) || (fifo_cnt != '0);
  assign tob.ovf_count   = ovf_cnt;
  assign tob.err_count   = err_cnt;

endmodule

// File: tb/tb_tob_tracker.sv
// tb/tb_tob_tracker.sv - self-checking bench for tob_tracker
module tb_tob_tracker;
  localparam int DEPTH  = 16;
  localparam int FDEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tob_tracker_if tif ();

  tob_tracker #(.DEPTH(DEPTH), .FIFO_DEPTH(FDEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tob   (tif)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int pulses  = 0;

  always @(negedge clk) if (tif.bbo_valid === 1'b1) pulses++;

  // Reference model: the order book as a set of slots
  bit          m_valid [DEPTH];
  logic [63:0] m_oid   [DEPTH];
  bit          m_side  [DEPTH];
  logic [31:0] m_px    [DEPTH];
  logic [31:0] m_qty   [DEPTH];
  int          m_err;
  int          m_ovf;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
    m_err = 0;
    m_ovf = 0;
  endtask

  task automatic model_apply(input bit typ, input logic [63:0] oid, input bit side,
                             input logic [31:0] qty, input logic [31:0] px, output bit ok);
    int slot;
    slot = -1;
    for (int i = 0; i < DEPTH; i++) if (m_valid[i] && m_oid[i] == oid) slot = i;
    ok = 1;
    if (typ == 0) begin
      if (slot < 0) begin
        for (int i = DEPTH - 1; i >= 0; i--) if (!m_valid[i]) slot = i;
      end
      if (slot < 0) begin
        m_err++;
        ok = 0;
      end else begin
        m_valid[slot] = 1;
        m_oid[slot]   = oid;
        m_side[slot]  = side;
        m_px[slot]    = px;
        m_qty[slot]   = qty;
      end
    end else begin
      if (slot < 0) begin
        m_err++;
        ok = 0;
      end else begin
        m_valid[slot] = 0;
      end
    end
  endtask

  // Best price of a side, then qty at that price from a second pass
  task automatic model_side(input bit side, output bit present,
                            output logic [31:0] px, output logic [31:0] qty);
    longint sum;
    bit     got;
    present = 0;
    px  = 0;
    qty = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_valid[i] && m_side[i] == side) begin
        if (!present) px = m_px[i];
        else if (side == 0 && m_px[i] > px) px = m_px[i];
        else if (side == 1 && m_px[i] < px) px = m_px[i];
        present = 1;
      end
    end
    sum = 0;
    got = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (present && m_valid[i] && m_side[i] == side && m_px[i] == px) begin
`ifdef TOB_QTY_AGG_EN
        sum = sum + longint'(m_qty[i]);
`else
        if (!got) sum = longint'(m_qty[i]);
`endif
        got = 1;
      end
    end
    qty = (sum > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : sum[31:0];
  endtask

  task automatic check_bbo(input string tag);
    bit          p;
    logic [31:0] px, q;
    model_side(0, p, px, q);
    check({tag, ".bid_present"}, tif.bid_present, p);
    check({tag, ".bid_price"},   tif.bid_price,   px);
    check({tag, ".bid_qty"},     tif.bid_qty,     q);
    model_side(1, p, px, q);
    check({tag, ".ask_present"}, tif.ask_present, p);
    check({tag, ".ask_price"},   tif.ask_price,   px);
    check({tag, ".ask_qty"},     tif.ask_qty,     q);
  endtask

  task automatic drive(input bit v, input bit typ, input logic [63:0] oid, input bit side,
                       input logic [31:0] qty, input logic [31:0] px);
    tif.tick_valid = v;
    tif.tick_type  = typ;
    tif.tick_oid   = oid;
    tif.tick_side  = side;
    tif.tick_qty   = qty;
    tif.tick_price = px;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (tif.busy === 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check("idle_timeout", 1, 0);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_tick(input string tag, input bit typ, input logic [63:0] oid, input bit side,
                         input logic [31:0] qty, input logic [31:0] px);
    int p0;
    bit ok;
    p0 = pulses;
    drive(1, typ, oid, side, qty, px);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    model_apply(typ, oid, side, qty, px, ok);
    wait_idle(100);
    check({tag, ".pulses"}, pulses - p0, ok ? 1 : 0);
    check({tag, ".err"}, tif.err_count, m_err);
    check_bbo(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
  endtask

  initial begin
    int  lat, p0;
    bit  ok;
    drive(0, 0, 0, 0, 0, 0);
    model_clear();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.bbo_valid", tif.bbo_valid, 0);
    check("rst.busy", tif.busy, 0);
    check("rst.ovf", tif.ovf_count, 0);
    check("rst.err", tif.err_count, 0);
    check_bbo("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // First add: latency and single pulse
    p0 = pulses;
    drive(1, 0, 1, 0, 10, 100);
    lat = 0;
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    lat = 1;
    while (tif.bbo_valid !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check("lat.edges", lat - 1, DEPTH + 2);
    model_apply(0, 1, 0, 10, 100, ok);
    check_bbo("lat");
    @(negedge clk);
    check("lat.pulse_width", tif.bbo_valid, 0);
    check("lat.pulses", pulses - p0, 1);

    // Directed sequence
    do_tick("add2", 0, 2, 0, 5, 100);
    do_tick("add3", 0, 3, 1, 7, 105);
    do_tick("del1", 1, 1, 0, 0, 0);
    do_tick("del99", 1, 99, 0, 0, 0);

    // Table full and overwrite
    do_reset();
    for (int k = 1; k <= DEPTH + 1; k++) do_tick("fill", 0, k, 0, k * 3, k);
    check("fill.bid_price", tif.bid_price, DEPTH);
    do_tick("ovwr", 0, 5, 0, 9, 200);
    check("ovwr.bid_price", tif.bid_price, 200);

    // Burst overflow: 12 ticks on consecutive edges
    do_reset();
    p0 = pulses;
    for (int k = 0; k < 12; k++) begin
      drive(1, 0, 100 + k, k % 2, k + 1, 10 + k);
      @(negedge clk);
      if (k < FDEPTH + 1) model_apply(0, 100 + k, k % 2, k + 1, 10 + k, ok);
      else m_ovf++;
    end
    drive(0, 0, 0, 0, 0, 0);
    wait_idle(400);
    check("burst.ovf", tif.ovf_count, m_ovf);
    check("burst.pulses", pulses - p0, FDEPTH + 1);
    check_bbo("burst");

    // Randomized ticks against the model
    do_reset();
    for (int k = 0; k < 60; k++) begin
      bit          typ;
      logic [31:0] q;
      typ = ($urandom_range(0, 3) == 0);
      q = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FF00 + $urandom_range(0, 255))
                                      : $urandom_range(1, 1000);
      do_tick("rnd", typ, $urandom_range(1, 20), $urandom_range(0, 1), q,
              $urandom_range(1, 12));
    end

    // Reset in the middle of a scan
    p0 = pulses;
    drive(1, 0, 1, 0, 4, 77);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_clear();
    check("mid.busy", tif.busy, 0);
    check("mid.err", tif.err_count, 0);
    check("mid.ovf", tif.ovf_count, 0);
    check_bbo("mid");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    check("mid.pulses", pulses - p0, 0);
    do_tick("mid_del1", 1, 1, 0, 0, 0);
    check("mid_del1.err", tif.err_count, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
